// File: rtl/hart_imem_arbiter.sv
// Round-robin arbiter that multiplexes per-hart I-cache refill requests onto one
// instruction-memory port, with one transaction in flight and a timeout watchdog.
module hart_imem_arbiter #(
    parameter int unsigned NUM_HARTS = 4,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TIMEOUT   = 255,
    localparam int unsigned GW       = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_HARTS-1:0]          i_IC_DataReq,
    input  logic [NUM_HARTS*ADDR_W-1:0]   i_IM_Addr,
    output logic [NUM_HARTS-1:0]          o_IC_MemReady,
    output logic [NUM_HARTS-1:0]          o_IC_Err,
    output logic [DATA_W-1:0]             o_IM_Instr,
    output logic                          o_mem_req,
    output logic [ADDR_W-1:0]             o_mem_addr,
    input  logic                          i_mem_ready,
    input  logic [DATA_W-1:0]             i_mem_data,
    output logic [GW-1:0]                 o_grant_id,
    output logic                          o_busy
);

    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    state_t         state;
    logic [GW-1:0]  ptr;
    logic [CW-1:0]  cnt;
    logic           found;
    logic [GW-1:0]  pick;
    logic [GW-1:0]  sel;
    logic           timed_out;

    // First requesting hart at or after ptr, wrapping modulo NUM_HARTS.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        sel   = '0;
        for (int unsigned i = 0; i < NUM_HARTS; i++) begin
            sel = GW'((32'(ptr) + i) % NUM_HARTS);
            if (!found && i_IC_DataReq[sel]) begin
                found = 1'b1;
                pick  = sel;
            end
        end
    end

    assign timed_out = (TIMEOUT != 0) && (cnt == TO_VAL);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state         <= IDLE;
            ptr           <= '0;
            cnt           <= '0;
            o_IC_MemReady <= '0;
            o_IC_Err      <= '0;
            o_IM_Instr    <= '0;
            o_mem_req     <= 1'b0;
            o_mem_addr    <= '0;
            o_grant_id    <= '0;
            o_busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_IC_MemReady <= '0;
                    o_IC_Err      <= '0;
                    if (found) begin
                        o_grant_id <= pick;
                        o_mem_addr <= i_IM_Addr[int'(pick)*ADDR_W +: ADDR_W];
                        o_mem_req  <= 1'b1;
                        o_busy     <= 1'b1;
                        cnt        <= '0;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    // Ready takes priority over a coincident timeout.
                    if (i_mem_ready) begin
                        o_IM_Instr                <= i_mem_data;
                        o_mem_req                 <= 1'b0;
                        o_IC_MemReady[o_grant_id] <= 1'b1;
                        state                     <= RESP;
                    end else if (timed_out) begin
                        o_IM_Instr                <= '0;
                        o_mem_req                 <= 1'b0;
                        o_IC_MemReady[o_grant_id] <= 1'b1;
                        o_IC_Err[o_grant_id]      <= 1'b1;
                        state                     <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    o_IC_MemReady <= '0;
                    o_IC_Err      <= '0;
                    o_busy        <= 1'b0;
                    cnt           <= '0;
                    ptr           <= (o_grant_id == GW'(NUM_HARTS - 1)) ? '0 : o_grant_id + 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hart_imem_arbiter.sv
// Randomized transaction-level bench for hart_imem_arbiter against a
// round-robin pointer model, plus directed latency/timeout/reset scenarios.
module tb_hart_imem_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic               i_clk = 1'b0;
    logic               i_rst = 1'b0;
    logic [N-1:0]       i_IC_DataReq = '0;
    logic [N*AW-1:0]    i_IM_Addr = '0;
    logic [N-1:0]       o_IC_MemReady;
    logic [N-1:0]       o_IC_Err;
    logic [DW-1:0]      o_IM_Instr;
    logic               o_mem_req;
    logic [AW-1:0]      o_mem_addr;
    logic               i_mem_ready = 1'b0;
    logic [DW-1:0]      i_mem_data = '0;
    logic [1:0]         o_grant_id;
    logic               o_busy;

    hart_imem_arbiter #(
        .NUM_HARTS(N),
        .ADDR_W(AW),
        .DATA_W(DW),
        .TIMEOUT(TO)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_IC_DataReq(i_IC_DataReq),
        .i_IM_Addr(i_IM_Addr),
        .o_IC_MemReady(o_IC_MemReady),
        .o_IC_Err(o_IC_Err),
        .o_IM_Instr(o_IM_Instr),
        .o_mem_req(o_mem_req),
        .o_mem_addr(o_mem_addr),
        .i_mem_ready(i_mem_ready),
        .i_mem_data(i_mem_data),
        .o_grant_id(o_grant_id),
        .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;
    int m_ptr    = 0;
    int last_g   = -1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] m, input int p);
        for (int i = 0; i < N; i++)
            if (m[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    task automatic check_idle();
        check_eq("idle_req", 64'(o_mem_req), 64'd0);
        check_eq("idle_busy", 64'(o_busy), 64'd0);
        check_eq("idle_rdy", 64'(o_IC_MemReady), 64'd0);
    endtask

    // Hart just served must keep its request low in the following IDLE cycle.
    task automatic legal_mask(input logic [N-1:0] want, output logic [N-1:0] mask);
        mask = want;
        if (last_g >= 0) mask[last_g] = 1'b0;
        if (mask == '0) begin
            i_IC_DataReq = '0;
            check_idle();
            @(negedge i_clk);
            last_g = -1;
            mask   = want;
        end
    endtask

    // Called at an IDLE negedge; returns at the following IDLE negedge.
    task automatic run_txn(input logic [N-1:0] want, input int w, input bit wiggle,
                           input bit fix, input logic [AW-1:0] fa, input logic [DW-1:0] fd,
                           output int g);
        logic [N-1:0]  mask;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        bit            to;
        int            last;
        legal_mask(want, mask);
        g = rr_pick(mask, m_ptr);
        for (int h = 0; h < N; h++)
            i_IM_Addr[h*AW +: AW] = (fix && h == g) ? fa : AW'($urandom);
        exp_addr     = i_IM_Addr[g*AW +: AW];
        exp_data     = '0;
        i_IC_DataReq = mask;
        check_idle();
        if (wiggle) begin
            i_mem_ready = 1'b1;
            i_mem_data  = DW'($urandom);
        end
        to   = (w > TO);
        last = to ? TO : w;
        @(negedge i_clk);
        for (int i = 0; i <= last; i++) begin
            if (i > 0) @(negedge i_clk);
            check_eq("req", 64'(o_mem_req), 64'd1);
            check_eq("addr", 64'(o_mem_addr), 64'(exp_addr));
            check_eq("grant", 64'(o_grant_id), 64'(g));
            check_eq("busy", 64'(o_busy), 64'd1);
            check_eq("no_rdy", 64'(o_IC_MemReady), 64'd0);
            i_mem_ready = (i == w);
            i_mem_data  = (fix && i == w) ? fd : DW'($urandom);
            if (i == w) exp_data = i_mem_data;
            if (wiggle) begin
                for (int h = 0; h < N; h++) i_IM_Addr[h*AW +: AW] = AW'($urandom);
                i_IC_DataReq[g] = 1'($urandom);
            end
        end
        @(negedge i_clk);
        check_eq("rdy", 64'(o_IC_MemReady), 64'(1 << g));
        check_eq("err", 64'(o_IC_Err), to ? 64'(1 << g) : 64'd0);
        check_eq("instr", 64'(o_IM_Instr), 64'(exp_data));
        check_eq("resp_req", 64'(o_mem_req), 64'd0);
        check_eq("resp_busy", 64'(o_busy), 64'd1);
        i_mem_ready     = wiggle ? 1'($urandom) : 1'b0;
        i_mem_data      = DW'($urandom);
        i_IC_DataReq[g] = 1'b0;
        m_ptr  = (g + 1) % N;
        last_g = g;
        @(negedge i_clk);
        i_mem_ready = 1'b0;
    endtask

    initial begin
        int g;
        logic [N-1:0] m;
        @(negedge i_clk);
        @(negedge i_clk);
        check_eq("rst_rdy", 64'(o_IC_MemReady), 64'd0);
        check_eq("rst_err", 64'(o_IC_Err), 64'd0);
        check_eq("rst_instr", 64'(o_IM_Instr), 64'd0);
        check_eq("rst_req", 64'(o_mem_req), 64'd0);
        check_eq("rst_addr", 64'(o_mem_addr), 64'd0);
        check_eq("rst_grant", 64'(o_grant_id), 64'd0);
        check_eq("rst_busy", 64'(o_busy), 64'd0);
        i_rst = 1'b1;
        @(negedge i_clk);

        // Single hart 2 fetch with fixed address/data.
        run_txn(4'b0100, 1, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, g);
        check_eq("d1_grant", 64'(g), 64'd2);

        // All harts requesting: round-robin order continues from ptr.
        for (int i = 0; i < 5; i++) begin
            run_txn(4'b1111, int'($urandom_range(0, 3)), 1'b0, 1'b0, '0, '0, g);
            check_eq("rr_order", 64'(g), 64'((3 + i) % N));
        end

        // Ready in the exact timeout cycle, then a pure timeout.
        run_txn(4'b1111, TO, 1'b0, 1'b0, '0, '0, g);
        run_txn(4'b1111, 40, 1'b0, 1'b0, '0, '0, g);

        // Request drop, address change and stray strobes around hart 1.
        run_txn(4'b0010, 3, 1'b1, 1'b1, 32'hA5A5_0010, 32'h1234_5678, g);
        check_eq("d6_grant", 64'(g), 64'd1);

        // Reset asserted during REQ, with ptr known to be non-zero.
        legal_mask(4'b1111, m);
        i_IC_DataReq = m;
        @(negedge i_clk);
        check_eq("pre_rst_req", 64'(o_mem_req), 64'd1);
        #2 i_rst = 1'b0;
        #1;
        check_eq("arst_req", 64'(o_mem_req), 64'd0);
        check_eq("arst_busy", 64'(o_busy), 64'd0);
        check_eq("arst_addr", 64'(o_mem_addr), 64'd0);
        check_eq("arst_grant", 64'(o_grant_id), 64'd0);
        @(negedge i_clk);
        i_rst        = 1'b1;
        i_IC_DataReq = '0;
        m_ptr        = 0;
        last_g       = -1;
        @(negedge i_clk);
        check_idle();
        @(negedge i_clk);
        run_txn(4'b1111, 0, 1'b0, 1'b0, '0, '0, g);
        check_eq("post_rst_grant", 64'(g), 64'd0);

        // Random traffic.
        for (int t = 0; t < 60; t++) begin
            logic [N-1:0] want;
            want = N'($urandom_range(1, (1 << N) - 1));
            run_txn(want, int'($urandom_range(0, 11)), 1'($urandom), 1'b0, '0, '0, g);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
